spi_slave_regfile: RTL and testbench

Parametrised SPI slave (mode 0 or mode 2) fronting a register bank of configurable width and depth. It is the next generation of the team's fixed 4×8-bit SPI slave. Additions: configurable data/address width, a base address, multi-word burst transfers with address auto-increment and wrap, write strobes, and a parallel register readout for the surrounding logic. It sits between the board SPI pins and core control logic, with all logic in the `clock` domain.

---
 rtl/spi_slave_regfile.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI slave (CPHA=0, selectable CPOL) in front of a register bank.
// Supports write/read bursts with address auto-increment and wrap, and exposes all
// registers in parallel.
//
// state | meaning
// IDLE  | waiting for a synchronised ss falling edge
// CMD   | shifting in the ID_W-bit command (slave ID)
// ADDR  | shifting in the ADDR_W-bit start address
// WDATA | shifting in write words, committing each complete word
// RDATA | shifting out read words, reloading the next word after each one
// SKIP  | unknown command, ignore sclk until ss rises
module spi_slave_regfile #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned BASE_ADDR = 'h10,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned SLAVE_IDW = 'hFF,
  parameter int unsigned SLAVE_IDR = 'h00,
  parameter bit          CPOL      = 1'b0,
  parameter int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic                       ss,
  input  logic                       sclk,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_strobe,
  output logic [IDX_W-1:0]           wr_index,
  output logic                       busy
);

  localparam int unsigned IN_W0 = (ID_W > ADDR_W) ? ID_W : ADDR_W;
  localparam int unsigned IN_W  = (IN_W0 > DATA_W) ? IN_W0 : DATA_W;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  localparam logic [ADDR_W-1:0] FIRST     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(BASE_ADDR + NUM_REGS - 1);
  localparam logic [ID_W-1:0]   CMD_WR    = ID_W'(SLAVE_IDW);
  localparam logic [ID_W-1:0]   CMD_RD    = ID_W'(SLAVE_IDR);
  localparam logic [CNT_W-1:0]  ID_LAST   = CNT_W'(ID_W - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, SKIP} state_t;

  state_t            state;
  logic              ss_meta, ss_1d, ss_2d;
  logic              sclk_meta, sclk_1d, sclk_2d;
  logic              mosi_meta, mosi_1d;
  logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic              sample_edge, shift_edge;
  logic [IN_W-1:0]   in_sh, in_nxt;
  logic [DATA_W-1:0] out_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic              is_wr, shift_pend, armed;
  logic [1:0]        settle;
  logic [DATA_W-1:0] regs [NUM_REGS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= FIRST) && (a <= LAST);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] d;
    d = a - FIRST;
    return d[IDX_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? FIRST : a + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    return in_range(a) ? regs[idx_of(a)] : '0;
  endfunction

  assign ss_fall     = ss_2d & ~ss_1d;
  assign ss_rise     = ~ss_2d & ss_1d;
  assign sclk_rise   = ~sclk_2d & sclk_1d;
  assign sclk_fall   = sclk_2d & ~sclk_1d;
  assign sample_edge = CPOL ? sclk_fall : sclk_rise;
  assign shift_edge  = CPOL ? sclk_rise : sclk_fall;
  assign in_nxt      = {in_sh[IN_W-2:0], mosi_1d};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*DATA_W +: DATA_W] = regs[i];
  end

  // Two-flop synchronisers plus one delay stage for edge detection; ss idles high.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ss_meta   <= 1'b1;
      ss_1d     <= 1'b1;
      ss_2d     <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_1d   <= 1'b0;
      sclk_2d   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_1d   <= 1'b0;
    end else begin
      ss_meta   <= ss;
      ss_1d     <= ss_meta;
      ss_2d     <= ss_1d;
      sclk_meta <= sclk;
      sclk_1d   <= sclk_meta;
      sclk_2d   <= sclk_1d;
      mosi_meta <= mosi;
      mosi_1d   <= mosi_meta;
    end
  end

  // Frame FSM, bit counter, register bank and miso shifter.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_index   <= '0;
      in_sh      <= '0;
      out_sh     <= '0;
      bit_cnt    <= '0;
      addr       <= '0;
      is_wr      <= 1'b0;
      shift_pend <= 1'b0;
      armed      <= 1'b0;
      settle     <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      wr_strobe  <= 1'b0;
      shift_pend <= shift_edge && (state == RDATA);
      // A frame cut by reset is ignored: only accept a new frame once the
      // synchroniser has flushed and ss has actually been seen high.
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && ss_2d) armed <= 1'b1;

      if (shift_pend && state == RDATA) begin
        miso   <= out_sh[DATA_W-1];
        out_sh <= out_sh << 1;
      end

      if (ss_rise) begin
        state   <= IDLE;
        busy    <= 1'b0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ss_fall && armed) begin
              state   <= CMD;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sample_edge) begin
              in_sh <= in_nxt;
              if (bit_cnt == ID_LAST) begin
                bit_cnt <= '0;
                if (in_nxt[ID_W-1:0] == CMD_WR) begin
                  state <= ADDR;
                  is_wr <= 1'b1;
                end else if (in_nxt[ID_W-1:0] == CMD_RD) begin
                  state <= ADDR;
                  is_wr <= 1'b0;
                end else begin
                  state <= SKIP;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ADDR: begin
            if (sample_edge) begin
              in_sh <= in_nxt;
              if (bit_cnt == ADDR_LAST) begin
                bit_cnt <= '0;
                addr    <= in_nxt[ADDR_W-1:0];
                if (is_wr) begin
                  state <= WDATA;
                end else begin
                  state   <= RDATA;
                  miso_oe <= 1'b1;
                  out_sh  <= read_word(in_nxt[ADDR_W-1:0]);
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WDATA: begin
            if (sample_edge) begin
              in_sh <= in_nxt;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                addr    <= addr_inc(addr);
                if (in_range(addr)) begin
                  regs[idx_of(addr)] <= in_nxt[DATA_W-1:0];
                  wr_strobe          <= 1'b1;
                  wr_index           <= idx_of(addr);
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          RDATA: begin
            if (sample_edge) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                addr    <= addr_inc(addr);
                out_sh  <= read_word(addr_inc(addr));
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          SKIP: begin
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: a CPOL=0 and a CPOL=1 instance share ss/mosi, the
// second sees the inverted sclk, so both must behave identically on every frame.
module tb_spi_slave_regfile;

  localparam int H = 8;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        ss = 1'b1;
  logic        sclk0 = 1'b0;
  logic        mosi = 1'b0;
  logic        sclk1;
  logic        miso0, oe0, strb0, busy0;
  logic        miso1, oe1, strb1, busy1;
  logic [1:0]  idx0, idx1;
  logic [31:0] q0, q1;

  assign sclk1 = ~sclk0;

  always #5 clock = ~clock;

  spi_slave_regfile #(.CPOL(1'b0)) dut0 (
    .clock(clock), .n_reset(n_reset), .ss(ss), .sclk(sclk0), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .reg_q(q0), .wr_strobe(strb0),
    .wr_index(idx0), .busy(busy0)
  );

  spi_slave_regfile #(.CPOL(1'b1)) dut1 (
    .clock(clock), .n_reset(n_reset), .ss(ss), .sclk(sclk1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .reg_q(q1), .wr_strobe(strb1),
    .wr_index(idx1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] m [4];
  int exp_q[$];
  int got0[$];
  int got1[$];
  logic [31:0] last_r0;
  int last_ns;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          nbits;
    logic [31:0] exp_r;
    int          exp_ns;
  } vec_t;

  vec_t tbl [11];

  // Record every strobe with its index.
  always @(posedge clock) begin
    if (strb0) got0.push_back(int'(idx0));
    if (strb1) got1.push_back(int'(idx1));
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_q();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  function automatic int next_addr(input int a);
    return (a == 'h13) ? 'h10 : (a + 1) % 256;
  endfunction

  // Reference: whole-word writes into in-range slots, reads from the current slot, wrap at the top.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] a_in,
                             input logic [31:0] wd, input int nbits, output logic [31:0] er);
    int a;
    logic [31:0] mask;
    a = int'(a_in);
    er = '0;
    for (int w = 0; w * 8 < nbits; w++) begin
      if (cmd == 8'hFF && (w + 1) * 8 <= nbits) begin
        if (a >= 'h10 && a < 'h14) begin
          m[a - 'h10] = wd[31 - 8 * w -: 8];
          exp_q.push_back(a - 'h10);
        end
        a = next_addr(a);
      end else if (cmd == 8'h00) begin
        er[31 - 8 * w -: 8] = (a >= 'h10 && a < 'h14) ? m[a - 'h10] : 8'h00;
        a = next_addr(a);
      end
    end
    mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
    er = er & mask;
  endtask

  task automatic send_bit(input logic b, output logic r0, output logic r1,
                          output logic o0, output logic o1);
    mosi = b;
    repeat (H) @(negedge clock);
    r0 = miso0;
    r1 = miso1;
    o0 = oe0;
    o1 = oe1;
    sclk0 = 1'b1;
    repeat (H) @(negedge clock);
    sclk0 = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wd,
                           input int nbits, output logic [31:0] r0, output logic [31:0] r1,
                           output int oe_err);
    logic [47:0] fb;
    logic a0, a1, o0, o1, exp_oe;
    fb = {cmd, addr, wd};
    r0 = '0;
    r1 = '0;
    oe_err = 0;
    ss = 1'b0;
    repeat (6) @(negedge clock);
    for (int i = 0; i < 16 + nbits; i++) begin
      send_bit(fb[47 - i], a0, a1, o0, o1);
      exp_oe = (cmd == 8'h00) && (i >= 16);
      if (o0 !== exp_oe) oe_err++;
      if (o1 !== exp_oe) oe_err++;
      if (i >= 16) begin
        r0[31 - (i - 16)] = a0;
        r1[31 - (i - 16)] = a1;
      end
    end
    repeat (6) @(negedge clock);
    ss = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic run_vec(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [31:0] wd, input int nbits);
    logic [31:0] er, r0, r1;
    int oe_err;
    exp_q.delete();
    got0.delete();
    got1.delete();
    model_frame(cmd, addr, wd, nbits, er);
    spi_frame(cmd, addr, wd, nbits, r0, r1, oe_err);
    last_r0 = r0;
    last_ns = got0.size();
    if (cmd == 8'h00) begin
      check({tag, " rdata cpol0"}, r0, er);
      check({tag, " rdata cpol1"}, r1, er);
    end
    check({tag, " miso_oe errors"}, oe_err, 0);
    check({tag, " strobes cpol0"}, got0.size(), exp_q.size());
    check({tag, " strobes cpol1"}, got1.size(), exp_q.size());
    if (got0.size() == exp_q.size() && got1.size() == exp_q.size()) begin
      foreach (exp_q[k]) begin
        check({tag, " wr_index cpol0"}, got0[k], exp_q[k]);
        check({tag, " wr_index cpol1"}, got1[k], exp_q[k]);
      end
    end
    check({tag, " reg_q cpol0"}, q0, model_q());
    check({tag, " reg_q cpol1"}, q1, model_q());
    check({tag, " busy idle"}, {busy0, busy1}, 2'b00);
  endtask

  initial begin
    logic d0, d1, d2, d3;
    logic [7:0] cmd, addr;
    logic [15:0] hdr;
    foreach (m[i]) m[i] = 8'h00;

    tbl[0]  = '{8'hFF, 8'h12, 32'hA500_0000,  8, 32'h0000_0000, 1};
    tbl[1]  = '{8'hFF, 8'h13, 32'h1122_3300, 24, 32'h0000_0000, 3};
    tbl[2]  = '{8'hFF, 8'h10, 32'hDEAD_BEEF, 32, 32'h0000_0000, 4};
    tbl[3]  = '{8'h00, 8'h12, 32'h0000_0000, 24, 32'hBEEF_DE00, 0};
    tbl[4]  = '{8'hFF, 8'h20, 32'h7700_0000,  8, 32'h0000_0000, 0};
    tbl[5]  = '{8'h00, 8'h20, 32'h0000_0000,  8, 32'h0000_0000, 0};
    tbl[6]  = '{8'h5A, 8'h10, 32'h1234_5678, 32, 32'h0000_0000, 0};
    tbl[7]  = '{8'hFF, 8'h12, 32'hF800_0000,  5, 32'h0000_0000, 0};
    tbl[8]  = '{8'hFF, 8'h12, 32'h5A00_0000,  8, 32'h0000_0000, 1};
    tbl[9]  = '{8'h00, 8'h13, 32'h0000_0000, 32, 32'hEFDE_AD5A, 0};
    tbl[10] = '{8'h00, 8'h0F, 32'h0000_0000, 16, 32'h00DE_0000, 0};

    repeat (3) @(negedge clock);
    check("reset ctl cpol0", {busy0, oe0, miso0, strb0, idx0}, 6'b0);
    check("reset ctl cpol1", {busy1, oe1, miso1, strb1, idx1}, 6'b0);
    check("reset reg_q", {q0 | q1}, 32'h0);
    n_reset = 1'b1;
    repeat (10) @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].nbits);
      check($sformatf("vec%0d table rdata", i), last_r0, tbl[i].exp_r);
      check($sformatf("vec%0d table strobes", i), last_ns, tbl[i].exp_ns);
      if (i == 0) check("single write reg_q", q0, 32'h00A5_0000);
    end

    // Reset mid-burst: outputs clear at once, the rest of the frame is ignored.
    ss = 1'b0;
    repeat (6) @(negedge clock);
    hdr = 16'hFF10;
    for (int i = 0; i < 16; i++) send_bit(hdr[15 - i], d0, d1, d2, d3);
    for (int i = 0; i < 3; i++) send_bit(1'b1, d0, d1, d2, d3);
    check("busy mid frame", {busy0, busy1}, 2'b11);
    n_reset = 1'b0;
    #1;
    check("async reset ctl cpol0", {busy0, oe0, miso0, strb0, idx0}, 6'b0);
    check("async reset ctl cpol1", {busy1, oe1, miso1, strb1, idx1}, 6'b0);
    check("async reset reg_q", {q0 | q1}, 32'h0);
    foreach (m[i]) m[i] = 8'h00;
    @(negedge clock);
    n_reset = 1'b1;
    got0.delete();
    got1.delete();
    for (int i = 0; i < 16; i++) send_bit(1'b1, d0, d1, d2, d3);
    check("ignored frame busy", {busy0, busy1}, 2'b00);
    check("ignored frame strobes", got0.size() + got1.size(), 0);
    check("ignored frame reg_q", {q0 | q1}, 32'h0);
    repeat (6) @(negedge clock);
    ss = 1'b1;
    repeat (10) @(negedge clock);
    run_vec("post reset write", 8'hFF, 8'h11, 32'hC300_0000, 8);
    check("post reset reg_q", q0, 32'h0000_C300);

    // Random frames against the reference model.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0, 1: cmd = 8'hFF;
        2:    cmd = 8'h00;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      addr = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range('h0E, 'h15));
      run_vec($sformatf("rand%0d", n), cmd, addr, $urandom, int'($urandom_range(1, 32)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
